// File: rtl/toeplitz_seed_loader.sv
// Runtime loader for the Toeplitz seed pair (reversed first row and first column).
// Optional macro SEED_NONZERO_CHECK_EN rejects all-zero seeds at commit time.
module toeplitz_seed_loader #(
   parameter int BS = 64,
   parameter int N  = 256,
   parameter int L  = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [BS-1:0] s_data,
   input  logic          s_valid,
   input  logic          s_last,
   output logic          s_ready,
   output logic [N-1:0]  rrow0,
   output logic [L-1:0]  col0,
   output logic          seed_valid,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int XSZ   = N / BS;
   localparam int YSZ   = L / BS;
   localparam int MAXSZ = (XSZ > YSZ) ? XSZ : YSZ;
   localparam int CW    = $clog2(MAXSZ) + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_COL = 2'd1,
      ST_LOAD_ROW = 2'd2,
      ST_COMMIT   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [L-1:0]   col_sh_q, col_sh_d;
   logic [N-1:0]   row_sh_q, row_sh_d;
   logic [N-1:0]   rrow_q, rrow_d;
   logic [L-1:0]   col_q, col_d;
   logic           seed_valid_q, seed_valid_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic           xfer_s;
   logic           commit_ok_s;

   assign s_ready    = (state_q == ST_LOAD_COL) || (state_q == ST_LOAD_ROW);
   assign busy       = (state_q != ST_IDLE);
   assign xfer_s     = s_valid && s_ready;
   assign rrow0      = rrow_q;
   assign col0       = col_q;
   assign seed_valid = seed_valid_q;
   assign done       = done_q;
   assign err        = err_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         col_sh_q     <= '0;
         row_sh_q     <= '0;
         rrow_q       <= '0;
         col_q        <= '0;
         seed_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         col_sh_q     <= col_sh_d;
         row_sh_q     <= row_sh_d;
         rrow_q       <= rrow_d;
         col_q        <= col_d;
         seed_valid_q <= seed_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Next-state logic. done_q is set on entry to COMMIT so it is high during COMMIT
   // and also gates the commit itself; err_q pulses in the cycle after a rejection.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      col_sh_d     = col_sh_q;
      row_sh_d     = row_sh_q;
      rrow_d       = rrow_q;
      col_d        = col_q;
      seed_valid_d = seed_valid_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      commit_ok_s  = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_LOAD_COL;
               cnt_d    = '0;
               col_sh_d = '0;
               row_sh_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_COL: begin
            if (xfer_s) begin
               for (int k = 0; k < YSZ; k++) begin
                  if (cnt_q == CW'(k)) begin
                     col_sh_d[L-1-k*BS -: BS] = s_data;
                  end
               end
               if (s_last) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(YSZ - 1)) begin
                  state_d = ST_LOAD_ROW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_LOAD_ROW: begin
            if (xfer_s) begin
               for (int k = 0; k < XSZ; k++) begin
                  if (cnt_q == CW'(k)) begin
                     row_sh_d[N-1-k*BS -: BS] = s_data;
                  end
               end
`ifdef SEED_NONZERO_CHECK_EN
               commit_ok_s = (|col_sh_d) && (|row_sh_d[N-1:1]);
`else
               commit_ok_s = 1'b1;
`endif
               if (cnt_q == CW'(XSZ - 1)) begin
                  cnt_d = '0;
                  if (s_last) begin
                     state_d = ST_COMMIT;
                     done_d  = commit_ok_s;
                     err_d   = !commit_ok_s;
                  end else begin
                     state_d = ST_IDLE;
                     err_d   = 1'b1;
                  end
               end else if (s_last) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_COMMIT: begin
            if (done_q) begin
               rrow_d       = row_sh_q >> 1;
               col_d        = col_sh_q;
               seed_valid_d = 1'b1;
            end else begin
               seed_valid_d = seed_valid_q;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end
endmodule
